// File: rtl/cache_fill_fsm.sv
// Miss-handling fill controller for a direct-mapped cache: requests one block
// from pipelined memory word by word and streams the returns into the data/tag arrays.
module cache_fill_fsm #(
  parameter  int ADDR_W = 16,
  parameter  int WORDS  = 8,
  parameter  int DATA_W = 16,
  localparam int CNT_W  = $clog2(WORDS),
  localparam int OFF_W  = $clog2(WORDS * DATA_W / 8),
  localparam int IDX_W  = 6,
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic [IDX_W-1:0]  set_index,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [WORDS-1:0]  word_enable,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [DATA_W-1:0] data_out
);

  typedef enum logic {IDLE, FILL} stateT;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W:0]    REQ_STEP   = 1;
  localparam logic [CNT_W-1:0]  RCV_STEP   = 1;
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(WORDS - 1);

  stateT             state;
  logic [CNT_W:0]    reqCnt;   // MSB is the "all requests issued" flag
  logic [CNT_W-1:0]  rcvCnt;
  logic [ADDR_W-1:0] baseAddr;

  logic reqDone;
  logic inFill;

  assign reqDone = reqCnt[CNT_W];
  assign inFill  = (state == FILL);

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is sampled on the clock edge, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      reqCnt   <= '0;
      rcvCnt   <= '0;
      baseAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state    <= FILL;
            baseAddr <= miss_address & BLOCK_MASK;
            reqCnt   <= '0;
            rcvCnt   <= '0;
          end
        end
        FILL: begin
          if (!reqDone) reqCnt <= reqCnt + REQ_STEP;
          if (memory_data_valid) begin
            rcvCnt <= rcvCnt + RCV_STEP;
            if (rcvCnt == LAST_WORD) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set and tag are fields of the latched block address, so they hold until the next miss.
  assign set_index = baseAddr[OFF_W +: IDX_W];
  assign fill_tag  = baseAddr[ADDR_W-1 -: TAG_W];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_busy         = inFill;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_enable      = '0;
    data_out         = memory_data;
    if (inFill) begin
      if (!reqDone) begin
        mem_read_en    = 1'b1;
        // Word offset stays inside the block: base has zero offset bits.
        memory_address = baseAddr + ADDR_W'({reqCnt[CNT_W-1:0], 1'b0});
      end
      if (memory_data_valid) begin
        write_data_array = 1'b1;
        word_enable      = WORDS'(1) << rcvCnt;
        write_tag_array  = (rcvCnt == LAST_WORD);
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a reference model plus a 4-cycle
// pipelined memory, with scoreboards for requests and data-array writes.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic [5:0]  set_index;
  logic [5:0]  fill_tag;
  logic [7:0]  word_enable;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] data_out;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .set_index         (set_index),
    .fill_tag          (fill_tag),
    .word_enable       (word_enable),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .data_out          (data_out)
  );

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } memReqT;

  typedef struct {
    logic [7:0]  we;
    logic [15:0] data;
    logic        last;
  } wrItemT;

  int checkCnt = 0;
  int errCnt   = 0;
  int cycleNum = 0;

  // Reference model state
  bit          mBusy = 1'b0;
  logic [15:0] mBase = '0;
  logic [5:0]  mSet  = '0;
  logic [5:0]  mTag  = '0;
  int          mReq  = 0;
  int          mRcv  = 0;
  int          missCycle = 0;

  int busyCnt, dataWrites, tagWrites, tagRel;

  logic [15:0] reqQ[$];
  wrItemT      wrQ[$];
  memReqT      memQ[$];

  bit          forceValid  = 1'b0;
  bit          missOnLast  = 1'b0;
  logic [15:0] lastMissAddr = '0;
  bit          rstDrv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycleNum);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] addr);
    return addr ^ 16'h5A3C;
  endfunction

  function automatic void clearStats();
    busyCnt    = 0;
    dataWrites = 0;
    tagWrites  = 0;
    tagRel     = -1;
  endfunction

  // One clock cycle: drive inputs, push expectations, sample at negedge, advance model.
  task automatic cycle(input bit miss, input logic [15:0] addr, input bit gate);
    bit          valid;
    bit          missEff;
    logic [15:0] addrEff;
    logic [15:0] data;
    wrItemT      item;
    wrItemT      got;
    logic [15:0] expAddr;

    valid = 1'b0;
    data  = 16'($urandom);
    if (forceValid) begin
      valid = 1'b1;
    end else if (gate && memQ.size() > 0 && memQ[0].ready <= cycleNum) begin
      valid = 1'b1;
      data  = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end
    missEff = miss || (missOnLast && mBusy && valid && mRcv == 7);
    addrEff = miss ? addr : lastMissAddr;

    rst               = rstDrv;
    miss_detected     = missEff;
    miss_address      = addrEff;
    memory_data_valid = valid;
    memory_data       = data;

    if (mBusy && valid) begin
      item.we   = 8'(1 << mRcv);
      item.data = data;
      item.last = (mRcv == 7);
      wrQ.push_back(item);
    end

    @(negedge clk);
    check("busy", fsm_busy, mBusy);
    check("rd_en", mem_read_en, (mBusy && mReq < 8));
    if (mem_read_en) begin
      check("req_pending", (reqQ.size() > 0), 1);
      if (reqQ.size() > 0) begin
        expAddr = reqQ.pop_front();
        check("req_addr", memory_address, expAddr);
      end
      memQ.push_back('{addr: memory_address, ready: cycleNum + 4});
    end else begin
      check("addr_quiet", memory_address, 0);
    end
    check("wr_data", write_data_array, (mBusy && valid));
    if (write_data_array) begin
      dataWrites++;
      check("wr_pending", (wrQ.size() > 0), 1);
      if (wrQ.size() > 0) begin
        got = wrQ.pop_front();
        check("word_en", word_enable, got.we);
        check("data_out", data_out, got.data);
        check("tag_wr", write_tag_array, got.last);
      end
      if (write_tag_array) begin
        tagWrites++;
        tagRel = cycleNum - missCycle;
      end
    end else begin
      check("we_quiet", word_enable, 0);
      check("tag_quiet", write_tag_array, 0);
    end
    check("set_index", set_index, mSet);
    check("fill_tag", fill_tag, mTag);
    if (fsm_busy) busyCnt++;

    @(posedge clk);
    if (rstDrv) begin
      mBusy = 1'b0; mBase = '0; mSet = '0; mTag = '0; mReq = 0; mRcv = 0;
      reqQ.delete();
      wrQ.delete();
    end else if (!mBusy) begin
      if (missEff) begin
        mBusy = 1'b1;
        mBase = {addrEff[15:4], 4'h0};
        mSet  = addrEff[9:4];
        mTag  = addrEff[15:10];
        mReq  = 0;
        mRcv  = 0;
        missCycle = cycleNum;
        for (int i = 0; i < 8; i++) reqQ.push_back(mBase + 16'(2 * i));
      end
    end else begin
      if (mReq < 8) mReq++;
      if (valid) begin
        if (mRcv == 7) mBusy = 1'b0;
        mRcv++;
      end
    end
    cycleNum++;
    #1;
  endtask

  task automatic runToIdle(input string tag, input int budget);
    int n = 0;
    while (mBusy && n < budget) begin
      cycle(1'b0, 16'h0000, 1'b1);
      n++;
    end
    check(tag, mBusy, 0);
  endtask

  initial begin
    bit pat[11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    bit gate;
    int n;

    rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rstDrv = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);
    rstDrv = 1'b0;
    cycle(1'b0, 16'h0000, 1'b1);

    // Miss at 0x3A46 with 4-cycle memory
    clearStats();
    cycle(1'b1, 16'h3A46, 1'b1);
    runToIdle("t1_done", 40);
    check("t1_busy_cycles", busyCnt, 12);
    check("t1_tag_rel", tagRel, 12);
    check("t1_writes", dataWrites, 8);
    check("t1_tag_writes", tagWrites, 1);
    check("t1_set", set_index, 6'd36);
    check("t1_tag", fill_tag, 6'd14);

    // Top of the address space: no wrap out of the block
    repeat (2) cycle(1'b0, 16'h0000, 1'b1);
    clearStats();
    cycle(1'b1, 16'hFFFF, 1'b1);
    runToIdle("t2_done", 40);
    check("t2_writes", dataWrites, 8);
    check("t2_set", set_index, 6'd63);
    check("t2_tag", fill_tag, 6'd63);

    // Returns with gaps
    cycle(1'b0, 16'h0000, 1'b1);
    clearStats();
    cycle(1'b1, 16'h1230, 1'b1);
    n = 1;
    while (mBusy && n < 40) begin
      gate = (n < 5) ? 1'b0 : ((n - 5 < 11) ? pat[n-5] : 1'b1);
      cycle(1'b0, 16'h0000, gate);
      n++;
    end
    check("t3_done", mBusy, 0);
    check("t3_writes", dataWrites, 8);
    check("t3_tag_writes", tagWrites, 1);
    check("t3_tag_rel", tagRel, 15);

    // Misses during the fill, including its final cycle, are ignored
    cycle(1'b0, 16'h0000, 1'b1);
    clearStats();
    missOnLast   = 1'b1;
    lastMissAddr = 16'hBEEF;
    cycle(1'b1, 16'h0420, 1'b1);
    n = 1;
    while (mBusy && n < 40) begin
      cycle((n == 3 || n == 9), 16'hC0DE, 1'b1);
      n++;
    end
    missOnLast = 1'b0;
    check("t4_done", mBusy, 0);
    check("t4_writes", dataWrites, 8);
    check("t4_set_held", set_index, 6'd2);
    check("t4_tag_held", fill_tag, 6'd1);
    cycle(1'b1, 16'h5550, 1'b1);
    check("t4_restart_busy", fsm_busy, 1);
    check("t4_restart_set", set_index, 6'd21);
    runToIdle("t4_done2", 40);

    // Reset after the third returned word
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h7770, 1'b1);
    n = 0;
    while (mRcv < 3 && n < 20) begin
      cycle(1'b0, 16'h0000, 1'b1);
      n++;
    end
    check("t5_three_words", mRcv, 3);
    rstDrv = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);
    rstDrv = 1'b0;
    clearStats();
    repeat (8) cycle(1'b0, 16'h0000, 1'b1);
    check("t5_no_writes", dataWrites, 0);
    check("t5_drained", memQ.size(), 0);
    check("t5_busy_cycles", busyCnt, 0);
    cycle(1'b1, 16'h0100, 1'b1);
    runToIdle("t5_done", 40);
    check("t5_writes", dataWrites, 8);
    check("t5_tag_rel", tagRel, 12);

    // memory_data_valid while idle
    clearStats();
    forceValid = 1'b1;
    repeat (3) cycle(1'b0, 16'h0000, 1'b1);
    forceValid = 1'b0;
    check("t6_no_writes", dataWrites, 0);

    check("reqq_empty", reqQ.size(), 0);
    check("wrq_empty", wrQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycleNum);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller for the direct-mapped cache: 64 sets, 16-byte blocks, 16-bit byte addresses.
- On a miss it latches the block address and issues 8 sequential word reads to the pipelined main memory.
- It streams each returned word into the data array with a one-hot word enable, then writes the tag on the last word.
- It sits directly upstream of the set-index decoder: set_index drives the decoder's 6-bit set input for the whole fill.

Parameters:
ADDR_W, 16, byte address width; the field split is tag [15:10], index [9:4], offset [3:0].
WORDS, 8, 16-bit words per block; fixes the counter widths at 3 bits plus a done flag.
DATA_W, 16, memory word width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  16  faulting byte address, valid with miss_detected
memory_data_valid  input  1  memory returns one word this cycle
memory_data  input  16  returned word
fsm_busy  output  1  fill in progress; stalls the pipeline
mem_read_en  output  1  read request strobe to memory
memory_address  output  16  word request address
set_index  output  6  set being filled, to the block-enable decoder
fill_tag  output  6  tag to write into the tag array
word_enable  output  8  one-hot word select into the data array
write_data_array  output  1  data array write strobe
write_tag_array  output  1  tag and valid write strobe
data_out  output  16  word to write; equals memory_data

Behaviour:
- Reset:
  - State is IDLE; req_cnt, rcv_cnt, base address, set_index and fill_tag are all 0.
  - All strobes, word_enable, memory_address and fsm_busy are 0.
  - Reset takes effect at the next rising edge. Reset mid-fill abandons the fill; memory words still in flight are ignored because IDLE ignores memory_data_valid.
- Two states, IDLE and FILL. Strobe outputs are combinational from state, counters and inputs. Address, index and tag outputs come from registers.
- IDLE:
  - fsm_busy=0, mem_read_en=0, write_*=0.
  - If miss_detected=1: latch base={miss_address[15:4],4'b0000} and clear both counters. Next state is FILL.
  - memory_data_valid is ignored.
- FILL, requests:
  - fsm_busy=1.
  - While req_cnt<8: mem_read_en=1 and memory_address=base+{req_cnt,1'b0}; req_cnt increments each cycle.
  - Exactly 8 requests on 8 consecutive cycles, starting the first FILL cycle.
  - Addresses never carry out of bits [3:0].
  - Once req_cnt=8: mem_read_en=0 and memory_address=0.
- FILL, returns:
  - On memory_data_valid=1: write_data_array=1, word_enable=1<<rcv_cnt, data_out=memory_data; rcv_cnt increments.
  - Returns are accepted in order. They may overlap the request phase, since memory is pipelined with 4-cycle latency, and may arrive with gaps.
- FILL, completion:
  - When memory_data_valid=1 and rcv_cnt=7: write_tag_array=1 in the same cycle as the 8th data write. Next state is IDLE.
  - fsm_busy drops the following cycle.
- Registered outputs:
  - set_index=base[9:4] and fill_tag=base[15:10], registered at the miss latch.
  - Both hold their value after the fill until the next miss.
- miss_detected during FILL is ignored. This includes the final cycle; a new miss is accepted in the first IDLE cycle after completion.
- With 4-cycle memory, a fill takes 12 cycles from the FILL entry edge to the final write_tag_array.

Test Plan:
- Miss at 0x3A46 with 4-cycle memory:
  - set_index=6'd36, fill_tag=6'd14.
  - Requests 0x3A40,0x3A42,…,0x3A4E on 8 consecutive cycles.
  - word_enable 0x01…0x80 in order.
  - write_tag_array once, together with word_enable=0x80; fsm_busy high for exactly 12 cycles.
- Miss at 0xFFFF:
  - Requests 0xFFF0…0xFFFE, no wrap to 0x0000.
  - set_index=63, fill_tag=63.
- Returns with gaps (valid pattern 1,0,0,1,1,0,1,1,1,1,1):
  - Exactly 8 data writes.
  - Tag write only on the 8th valid; FSM stays busy through the gaps.
- miss_detected pulsed mid-fill and on the final cycle:
  - No restart and no address change.
  - A miss asserted in the cycle after completion starts a new fill.
- rst asserted after the 3rd returned word:
  - Next cycle fsm_busy=0 and all strobes 0.
  - Further memory_data_valid pulses cause no writes.
  - A subsequent miss restarts at word 0.
- memory_data_valid while IDLE: no write_data_array, word_enable stays 0.
